// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI slave port between MASTERS requesters.
// The selection is locked from an ungranted request until its grant, so the
// address phase stays stable. Every accepted transaction pushes the issuing
// master index into an ID FIFO. In-order responses are routed back to the
// master at the FIFO head.
//
// Handshake rules:
//   - Address phase: a transfer is accepted in the cycle where
//     slave_req_o && slave_gnt_i. The master sees master_gnt_o in that same
//     cycle. Once a request is stalled by a low gnt, the selected master is
//     held until it is granted or it drops its request.
//   - Response phase: slave_rvalid_i is a single-cycle pulse per accepted
//     transaction, returned in order. It is forwarded with zero latency to the
//     master at the FIFO head.
module obi_rr_arbiter #(
    parameter int MASTERS     = 3,
    parameter int OUTSTANDING = 2,
    parameter int MASTER_BITS = (MASTERS == 1) ? 1 : $clog2(MASTERS),
    parameter int CNT_BITS    = $clog2(OUTSTANDING + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                master_req_i    [MASTERS],
    output logic                master_gnt_o    [MASTERS],
    input  logic                master_we_i     [MASTERS],
    input  logic [3:0]          master_be_i     [MASTERS],
    input  logic [31:0]         master_addr_i   [MASTERS],
    input  logic [31:0]         master_wdata_i  [MASTERS],
    output logic                master_rvalid_o [MASTERS],
    output logic [31:0]         master_rdata_o  [MASTERS],
    output logic                slave_req_o,
    input  logic                slave_gnt_i,
    output logic                slave_we_o,
    output logic [3:0]          slave_be_o,
    output logic [31:0]         slave_addr_o,
    output logic [31:0]         slave_wdata_o,
    input  logic                slave_rvalid_i,
    input  logic [31:0]         slave_rdata_i,
    output logic [CNT_BITS-1:0] outstanding_o,
    output logic                rsp_err_o
);

    localparam int PTR_BITS = (OUTSTANDING == 1) ? 1 : $clog2(OUTSTANDING);
    localparam logic [MASTER_BITS:0] L_MASTERS   = (MASTER_BITS + 1)'(MASTERS);
    localparam logic [MASTER_BITS-1:0] L_LAST_M  = MASTER_BITS'(MASTERS - 1);
    localparam logic [CNT_BITS-1:0]  L_FULL_CNT  = CNT_BITS'(OUTSTANDING);
    localparam logic [PTR_BITS-1:0]  L_LAST_PTR  = PTR_BITS'(OUTSTANDING - 1);

    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;

    logic [0:0]             r_state;
    logic [MASTER_BITS-1:0] r_lock_idx;
    logic [MASTER_BITS-1:0] r_rr_ptr;
    logic [MASTER_BITS-1:0] r_fifo [OUTSTANDING];
    logic [PTR_BITS-1:0]    r_wr_ptr;
    logic [PTR_BITS-1:0]    r_rd_ptr;
    logic [CNT_BITS-1:0]    r_count;
    logic                   r_rsp_err;

    logic [MASTER_BITS-1:0] w_arb_idx;
    logic                   w_arb_found;
    logic [MASTER_BITS:0]   w_scan;
    logic [MASTER_BITS-1:0] w_sel;
    logic [MASTER_BITS-1:0] w_next_rr;
    logic [MASTER_BITS-1:0] w_head;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_slave_req;
    logic                   w_accept;
    logic                   w_pop;

    function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
        return (p == L_LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Round-robin scan: first requester at or above r_rr_ptr, with wrap-around.
    always_comb begin
        w_arb_idx   = r_rr_ptr;
        w_arb_found = 1'b0;
        w_scan      = '0;
        for (int i = 0; i < MASTERS; i++) begin
            w_scan = {1'b0, r_rr_ptr} + (MASTER_BITS + 1)'(i);
            if (w_scan >= L_MASTERS) begin
                w_scan = w_scan - L_MASTERS;
            end
            if (!w_arb_found && master_req_i[w_scan[MASTER_BITS-1:0]]) begin
                w_arb_idx   = w_scan[MASTER_BITS-1:0];
                w_arb_found = 1'b1;
            end
        end
    end

    assign w_sel       = (r_state == ST_LOCKED) ? r_lock_idx : w_arb_idx;
    assign w_full      = (r_count == L_FULL_CNT);
    assign w_empty     = (r_count == '0);
    assign w_slave_req = master_req_i[w_sel] & ~w_full;
    assign w_accept    = w_slave_req & slave_gnt_i;
    assign w_pop       = slave_rvalid_i & ~w_empty;
    assign w_head      = r_fifo[r_rd_ptr];
    assign w_next_rr   = (MASTERS == 1 || w_sel == L_LAST_M) ? '0 : w_sel + 1'b1;

    assign slave_req_o   = w_slave_req;
    assign slave_we_o    = master_we_i[w_sel];
    assign slave_be_o    = master_be_i[w_sel];
    assign slave_addr_o  = master_addr_i[w_sel];
    assign slave_wdata_o = master_wdata_i[w_sel];
    assign outstanding_o = r_count;
    assign rsp_err_o     = r_rsp_err;

    // Per-master grant and response demux; read data is broadcast.
    always_comb begin
        for (int i = 0; i < MASTERS; i++) begin
            master_gnt_o[i]    = w_accept && (w_sel == MASTER_BITS'(i));
            master_rvalid_o[i] = w_pop && (w_head == MASTER_BITS'(i));
            master_rdata_o[i]  = slave_rdata_i;
        end
    end

    // Lock FSM: hold the selection while a request waits for its grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_UNLOCKED;
            r_lock_idx <= '0;
        end else begin
            case (r_state)
                ST_UNLOCKED: begin
                    if (w_slave_req && !slave_gnt_i) begin
                        r_state    <= ST_LOCKED;
                        r_lock_idx <= w_sel;
                    end
                end
                default: begin
                    // Granted, or the master abandoned its request.
                    if (w_accept || !master_req_i[r_lock_idx]) begin
                        r_state <= ST_UNLOCKED;
                    end
                end
            endcase
        end
    end

    // Round-robin pointer advances past the master just accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= w_next_rr;
        end
    end

    // ID FIFO: push on accept and pop on response. Both can happen in one
    // cycle; the pop reads the old head before the new entry matters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < OUTSTANDING; i++) begin
                r_fifo[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_fifo[r_wr_ptr] <= w_sel;
                r_wr_ptr         <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error when a response arrives with nothing outstanding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_err <= 1'b0;
        end else if (slave_rvalid_i && w_empty) begin
            r_rsp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Directed bench for obi_rr_arbiter (3 masters, 2 outstanding). The expected
// master index is queued at each predicted grant and popped at each response.
module tb_obi_rr_arbiter;

    localparam int M  = 3;
    localparam int CB = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_req    [M];
    logic        m_gnt    [M];
    logic        m_we     [M];
    logic [3:0]  m_be     [M];
    logic [31:0] m_addr   [M];
    logic [31:0] m_wdata  [M];
    logic        m_rvalid [M];
    logic [31:0] m_rdata  [M];
    logic        s_req, s_gnt, s_we, s_rvalid;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [CB-1:0] outst;
    logic        rsp_err;

    logic [1:0]  exp_q [$];
    int          tests = 0;
    int          fails = 0;
    logic [2:0]  gnt_vec, rv_vec;

    assign gnt_vec = {m_gnt[2], m_gnt[1], m_gnt[0]};
    assign rv_vec  = {m_rvalid[2], m_rvalid[1], m_rvalid[0]};

    obi_rr_arbiter #(.MASTERS(3), .OUTSTANDING(2)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .master_req_i(m_req), .master_gnt_o(m_gnt), .master_we_i(m_we),
        .master_be_i(m_be), .master_addr_i(m_addr), .master_wdata_i(m_wdata),
        .master_rvalid_o(m_rvalid), .master_rdata_o(m_rdata),
        .slave_req_o(s_req), .slave_gnt_i(s_gnt), .slave_we_o(s_we),
        .slave_be_o(s_be), .slave_addr_o(s_addr), .slave_wdata_o(s_wdata),
        .slave_rvalid_i(s_rvalid), .slave_rdata_i(s_rdata),
        .outstanding_o(outst), .rsp_err_o(rsp_err)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [2:0] v);
        for (int i = 0; i < M; i++) m_req[i] = v[i];
    endtask

    // One bus cycle. exp_gnt is the master expected to be granted (-1: none).
    // rv drives slave_rvalid_i. The expected response owner comes from the queue.
    task automatic cycle(input string tag, input int exp_gnt, input logic rv);
        logic [1:0] e;
        logic [2:0] exp_rv;
        logic [2:0] exp_g;
        s_rvalid = rv;
        s_rdata  = $urandom;
        #1;
        exp_rv = 3'b000;
        e      = 2'd0;
        if (rv && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            exp_rv[e] = 1'b1;
        end
        chk({tag, "_rvalid"}, {29'd0, rv_vec}, {29'd0, exp_rv});
        if (exp_rv != 3'b000) chk({tag, "_rdata"}, m_rdata[e], s_rdata);
        exp_g = 3'b000;
        if (exp_gnt >= 0) exp_g[exp_gnt] = 1'b1;
        chk({tag, "_gnt"}, {29'd0, gnt_vec}, {29'd0, exp_g});
        if (exp_gnt >= 0) begin
            chk({tag, "_addr"}, s_addr, m_addr[exp_gnt]);
            chk({tag, "_wdata"}, s_wdata, m_wdata[exp_gnt]);
            exp_q.push_back(2'(exp_gnt));
        end
        @(posedge clk);
        #1;
        s_rvalid = 1'b0;
    endtask

    initial begin
        // Reset block and idle inputs
        for (int i = 0; i < M; i++) begin
            m_req[i]   = 1'b0;
            m_we[i]    = i[0];
            m_be[i]    = 4'hF;
            m_addr[i]  = 32'h100 * i;
            m_wdata[i] = $urandom;
        end
        s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
        #1;
        chk("rst_outst", {30'd0, outst}, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_gnt", {29'd0, gnt_vec}, 32'd0);
        chk("rst_rvalid", {29'd0, rv_vec}, 32'd0);
        chk("rst_sreq", {31'd0, s_req}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Round robin with all masters requesting, response one cycle later
        set_req(3'b111); s_gnt = 1'b1;
        cycle("rr0", 0, 1'b0);
        cycle("rr1", 1, 1'b1);
        cycle("rr2", 2, 1'b1);
        cycle("rr3", 0, 1'b1);
        cycle("rr4", 1, 1'b1);
        cycle("rr5", 2, 1'b1);
        set_req(3'b000);
        cycle("rr_drain", -1, 1'b1);
        chk("rr_outst", {30'd0, outst}, 32'd0);

        // Lock: M1 stalled 3 cycles while M0 joins
        set_req(3'b010); s_gnt = 1'b0; #1;
        chk("lock_addr1", s_addr, 32'h100);
        chk("lock_sreq", {31'd0, s_req}, 32'd1);
        cycle("lock1", -1, 1'b0);
        set_req(3'b011); #1;
        chk("lock_addr2", s_addr, 32'h100);
        cycle("lock2", -1, 1'b0);
        chk("lock_addr3", s_addr, 32'h100);
        cycle("lock3", -1, 1'b0);
        s_gnt = 1'b1;
        cycle("lock_gnt", 1, 1'b0);
        set_req(3'b001);
        cycle("lock_next", 0, 1'b0);
        set_req(3'b000);
        cycle("lock_rsp1", -1, 1'b1);
        cycle("lock_rsp0", -1, 1'b1);
        chk("lock_outst", {30'd0, outst}, 32'd0);

        // FIFO full backpressure
        set_req(3'b111);
        cycle("fill1", 1, 1'b0);
        cycle("fill2", 2, 1'b0);
        chk("full_outst", {30'd0, outst}, 32'd2);
        chk("full_sreq", {31'd0, s_req}, 32'd0);
        cycle("full_hold", -1, 1'b0);
        s_rvalid = 1'b1; #1;
        chk("full_sreq_rv", {31'd0, s_req}, 32'd0);
        cycle("full_pop", -1, 1'b1);
        chk("pop_outst", {30'd0, outst}, 32'd1);
        chk("pop_sreq", {31'd0, s_req}, 32'd1);
        cycle("refill", 0, 1'b0);
        set_req(3'b000);
        cycle("full_rsp2", -1, 1'b1);
        cycle("full_rsp0", -1, 1'b1);

        // Simultaneous accept (M2) and response (earlier M0)
        set_req(3'b001);
        cycle("sim_a0", 0, 1'b0);
        set_req(3'b100);
        cycle("sim_both", 2, 1'b1);
        chk("sim_outst", {30'd0, outst}, 32'd1);
        set_req(3'b000);
        cycle("sim_rsp2", -1, 1'b1);
        chk("sim_outst0", {30'd0, outst}, 32'd0);

        // Response with empty FIFO
        cycle("err_pulse", -1, 1'b1);
        chk("err_set", {31'd0, rsp_err}, 32'd1);
        cycle("err_idle", -1, 1'b0);
        chk("err_sticky", {31'd0, rsp_err}, 32'd1);

        // Reset with two outstanding and a non-zero rr pointer
        set_req(3'b111);
        cycle("pre_rst0", 0, 1'b0);
        cycle("pre_rst1", 1, 1'b0);
        chk("pre_rst_outst", {30'd0, outst}, 32'd2);
        set_req(3'b000); s_gnt = 1'b0;
        rst_n = 1'b0; s_rvalid = 1'b1; #1;
        chk("mid_rst_outst", {30'd0, outst}, 32'd0);
        chk("mid_rst_err", {31'd0, rsp_err}, 32'd0);
        chk("mid_rst_gnt", {29'd0, gnt_vec}, 32'd0);
        chk("mid_rst_rvalid", {29'd0, rv_vec}, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        s_rvalid = 1'b0; rst_n = 1'b1;
        cycle("late_rv", -1, 1'b1);
        chk("late_err", {31'd0, rsp_err}, 32'd1);
        s_gnt = 1'b1; set_req(3'b110);
        cycle("post_rst", 1, 1'b0);
        set_req(3'b000);
        cycle("post_rsp", -1, 1'b1);
        chk("end_outst", {30'd0, outst}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
